// File: rtl/oup_ulpi_pkg.sv
// Shared types and constants for the ULPI register access engine.
// Extended (8-bit) addressing is enabled by OUP_ULPI_REGACCESS_EXT_EN.
package oup_ulpi_pkg;

  localparam logic [1:0] REGW          = 2'b10;
  localparam logic [1:0] REGR          = 2'b11;
  localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TXCMD,
    ST_EXTADDR,
    ST_WDATA,
    ST_STP,
    ST_RD_TURN,
    ST_RD_DATA,
    ST_RD_END,
    ST_ABORT_WAIT,
    ST_DONE
  } ulpi_regfsm_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ulpi_req_t;

  function automatic logic is_ext(input logic [7:0] a);
    return a > 8'h3F;
  endfunction

  function automatic logic [7:0] txcmd_byte(input ulpi_req_t r);
    logic [5:0] a;
    a = is_ext(r.addr) ? EXT_ADDR_CODE : r.addr[5:0];
    return {(r.write ? REGW : REGR), a};
  endfunction

endpackage

// File: rtl/oup_ulpi_regaccess.sv
// ULPI register read/write engine: TX CMD sequencing, PHY-abort retry, timeout.
// Define OUP_ULPI_REGACCESS_EXT_EN to enable extended (0x2F) register addressing.
module oup_ulpi_regaccess
  import oup_ulpi_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  input  logic       bus_grant_i,
  output logic       bus_busy_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o
);

  localparam int               RTY_W    = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  ulpi_regfsm_t     state_q, state_d;
  ulpi_req_t        req_q, req_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             err_q, err_d;
  logic [7:0]       rd_q, rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             busy_q, busy_d;
  logic [7:0]       data_q, data_d;
  logic             stp_q, stp_d;
  logic             accept, abort, timed_out;

  assign req_ready_o = !rst_i && (state_q == ST_IDLE) && !ulpi_dir_i && bus_grant_i;

  always_comb begin
    accept    = req_valid_i && req_ready_o;
    abort     = 1'b0;
    timed_out = 1'b0;
    state_d   = state_q;
    req_d     = req_q;
    retry_d   = retry_q;
    err_d     = err_q;
    rd_d      = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d.write = req_write_i;
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          retry_d     = '0;
          err_d       = 1'b0;
          state_d     = ST_TXCMD;
`ifndef OUP_ULPI_REGACCESS_EXT_EN
          // Without extended addressing, high addresses fail without touching the bus.
          if (is_ext(req_addr_i)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      ST_TXCMD: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) begin
`ifdef OUP_ULPI_REGACCESS_EXT_EN
          if (is_ext(req_q.addr)) state_d = ST_EXTADDR;
          else
`endif
          state_d = req_q.write ? ST_WDATA : ST_RD_TURN;
        end
      end
`ifdef OUP_ULPI_REGACCESS_EXT_EN
      ST_EXTADDR: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) state_d = req_q.write ? ST_WDATA : ST_RD_TURN;
      end
`endif
      ST_WDATA: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) state_d = ST_STP;
      end
      ST_STP:     state_d = ST_DONE;
      ST_RD_TURN: if (ulpi_dir_i) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (ulpi_dir_i) begin
          rd_d    = ulpi_data_i;
          state_d = ST_RD_END;
        end
      end
      ST_RD_END:     if (!ulpi_dir_i) state_d = ST_DONE;
      ST_ABORT_WAIT: if (!ulpi_dir_i && bus_grant_i) state_d = ST_TXCMD;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // A dir rise wins over a same-cycle nxt; the PHY has taken the bus.
    if (abort) begin
      retry_d = retry_q + 1'b1;
      if (retry_q >= RTY_MAX) begin
        state_d = ST_DONE;
        err_d   = 1'b1;
      end else begin
        state_d = ST_ABORT_WAIT;
      end
    end

    if (state_q != ST_IDLE && state_d == state_q && tmo_q == TMO_LAST) begin
      timed_out = 1'b1;
      err_d     = 1'b1;
      state_d   = (!ulpi_dir_i && state_q != ST_ABORT_WAIT) ? ST_STP : ST_DONE;
    end

    tmo_d = (state_q == ST_IDLE || state_d != state_q || timed_out) ? '0 : tmo_q + 1'b1;

    busy_d      = !(state_d inside {ST_IDLE, ST_ABORT_WAIT});
    stp_d       = (state_d == ST_STP);
    rsp_valid_d = (state_d == ST_DONE);
    case (state_d)
      ST_TXCMD:   data_d = txcmd_byte(req_d);
      ST_EXTADDR: data_d = req_d.addr;
      ST_WDATA:   data_d = req_d.wdata;
      default:    data_d = 8'h00;
    endcase
    rsp_err_d   = rsp_valid_d ? err_d : rsp_err_q;
    rsp_rdata_d = (rsp_valid_d && !err_d && !req_d.write) ? rd_d : rsp_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    req_q <= req_d;
    rd_q  <= rd_d;
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      stp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      stp_q       <= stp_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign bus_busy_o  = busy_q;
  assign ulpi_data_o = data_q;
  assign ulpi_stp_o  = stp_q;

endmodule

// File: tb/tb_oup_ulpi_regaccess.sv
// Directed bench for oup_ulpi_regaccess: per-cycle expected bus trace plus literal pins.
module tb_oup_ulpi_regaccess;

  localparam int TMO = 64;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       bus_grant, busy;
  logic       ulpi_dir, ulpi_nxt, ulpi_stp;
  logic [7:0] ulpi_din, ulpi_dout;

  oup_ulpi_regaccess #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .bus_grant_i(bus_grant), .bus_busy_o(busy),
    .ulpi_dir_i(ulpi_dir), .ulpi_nxt_i(ulpi_nxt), .ulpi_data_i(ulpi_din),
    .ulpi_data_o(ulpi_dout), .ulpi_stp_o(ulpi_stp)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, set by the stimulus
  logic       chk_en = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic       e_stp = 1'b0, e_busy = 1'b0, e_vld = 1'b0, e_rdy = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int         lit_cmd = -1, lit_lat = -1, lit_rises = -1, lit_rdata = -1;

  // Owned by the compare process
  int   total = 0, bad = 0;
  int   cyc_n = 0, acc_cyc = 0, rises = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      acc_cyc = cyc_n;
      rises   = 0;
    end
    if (busy && !busy_prev) begin
      rises++;
      if (lit_cmd >= 0) chk("cmd_byte_literal", {24'h0, ulpi_dout}, lit_cmd);
    end
    busy_prev = busy;
    if (chk_en) begin
      chk("ulpi_data_o", {24'h0, ulpi_dout}, {24'h0, e_data});
      chk("ulpi_stp_o", {31'h0, ulpi_stp}, {31'h0, e_stp});
      chk("bus_busy_o", {31'h0, busy}, {31'h0, e_busy});
      chk("rsp_valid_o", {31'h0, rsp_valid}, {31'h0, e_vld});
      chk("req_ready_o", {31'h0, req_ready}, {31'h0, e_rdy});
      chk("rsp_err_o", {31'h0, rsp_err}, {31'h0, m_err});
      chk("rsp_rdata_o", {24'h0, rsp_rdata}, {24'h0, m_rdata});
      if (rsp_valid) begin
        if (lit_lat >= 0)   chk("rsp_latency", cyc_n - acc_cyc, lit_lat);
        if (lit_rises >= 0) chk("cmd_issues", rises, lit_rises);
        if (lit_rdata >= 0) chk("rdata_literal", {24'h0, rsp_rdata}, lit_rdata);
      end
    end
  end

  // Spec-level model helpers
  function automatic logic [7:0] cmd_of(input logic w, input logic [7:0] a);
    logic [5:0] low;
    low = (a > 8'h3F) ? 6'h2F : a[5:0];
    return {1'b1, !w, low};
  endfunction

  function automatic logic addr_ok(input logic [7:0] a);
`ifdef OUP_ULPI_REGACCESS_EXT_EN
    return 1'b1;
`else
    return a <= 8'h3F;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input logic [7:0] d, input logic s, input logic b, input logic v);
    e_data = d; e_stp = s; e_busy = b; e_vld = v; e_rdy = 1'b0;
  endtask

  task automatic arm(input int c, input int l, input int r, input int d);
    lit_cmd = c; lit_lat = l; lit_rises = r; lit_rdata = d;
  endtask

  task automatic accept(input logic w, input logic [7:0] a, input logic [7:0] d);
    expect_o(8'h00, 1'b0, 1'b0, 1'b0);
    e_rdy = 1'b1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    bus_grant = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
    tick();
    req_valid = 1'b0; bus_grant = 1'b0;
  endtask

  task automatic finish_rsp(input logic err, input logic upd, input logic [7:0] val);
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
    expect_o(8'h00, 1'b0, 1'b1, 1'b1);
    m_err = err;
    if (!err && upd) m_rdata = val;
    tick();
    expect_o(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int lat);
    for (int k = 0; k <= lat; k++) begin
      expect_o(b, 1'b0, 1'b1, 1'b0);
      ulpi_nxt = (k == lat);
      tick();
    end
    ulpi_nxt = 1'b0;
  endtask

  task automatic write_txn(input logic [7:0] a, input logic [7:0] d, input int lat, input int naborts);
    accept(1'b1, a, d);
    if (!addr_ok(a)) begin
      finish_rsp(1'b1, 1'b0, 8'h00);
      return;
    end
    for (int i = 0; i < naborts; i++) begin
      expect_o(cmd_of(1'b1, a), 1'b0, 1'b1, 1'b0);
      ulpi_dir = 1'b1;
      tick();
      if (i + 1 > MR) begin
        finish_rsp(1'b1, 1'b0, 8'h00);
        return;
      end
      expect_o(8'h00, 1'b0, 1'b0, 1'b0);
      ulpi_dir = 1'b1; bus_grant = 1'b0;
      tick();
      expect_o(8'h00, 1'b0, 1'b0, 1'b0);
      ulpi_dir = 1'b0; bus_grant = 1'b1;
      tick();
      bus_grant = 1'b0;
    end
    send_byte(cmd_of(1'b1, a), lat);
    if (a > 8'h3F) send_byte(a, lat);
    send_byte(d, lat);
    expect_o(8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    finish_rsp(1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_txn(input logic [7:0] a, input int lat, input logic [7:0] val);
    accept(1'b0, a, 8'h00);
    if (!addr_ok(a)) begin
      finish_rsp(1'b1, 1'b0, 8'h00);
      return;
    end
    send_byte(cmd_of(1'b0, a), lat);
    if (a > 8'h3F) send_byte(a, lat);
    expect_o(8'h00, 1'b0, 1'b1, 1'b0); ulpi_dir = 1'b1; tick();
    expect_o(8'h00, 1'b0, 1'b1, 1'b0); ulpi_dir = 1'b1; ulpi_din = val; tick();
    expect_o(8'h00, 1'b0, 1'b1, 1'b0); ulpi_dir = 1'b0; ulpi_din = 8'h00; tick();
    finish_rsp(1'b0, 1'b1, val);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    bus_grant = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_din = 8'h00;
    tick();
    expect_o(8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0; bus_grant = 1'b0;
    tick();

    arm(8'h96, 4, 1, -1);  write_txn(8'h16, 8'hA5, 0, 0);
    arm(8'hC0, 5, 1, 8'h24); read_txn(8'h00, 0, 8'h24);
    arm(8'h8A, -1, 1, -1); write_txn(8'h0A, 8'h55, 2, 0);
    arm(8'hFF, -1, 1, 8'hE7); read_txn(8'h3F, 1, 8'hE7);
`ifdef OUP_ULPI_REGACCESS_EXT_EN
    arm(8'hAF, 5, 1, -1);  write_txn(8'h85, 8'h3C, 0, 0);
    arm(8'hEF, 6, 1, 8'h99); read_txn(8'h40, 0, 8'h99);
`else
    arm(-1, 1, -1, 8'hE7); write_txn(8'h85, 8'h3C, 0, 0);
    arm(-1, 1, -1, 8'hE7); read_txn(8'h40, 0, 8'h99);
`endif
    arm(8'h96, -1, 4, -1); write_txn(8'h16, 8'h11, 0, 4);
    arm(8'h96, -1, 3, -1); write_txn(8'h16, 8'h22, 0, 2);

    // nxt never comes: TX CMD held for the full timeout, then stp and error
    arm(8'h93, TMO + 2, 1, -1);
    accept(1'b1, 8'h13, 8'h44);
    for (int k = 0; k < TMO; k++) begin
      expect_o(8'h93, 1'b0, 1'b1, 1'b0);
      tick();
    end
    expect_o(8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    finish_rsp(1'b1, 1'b0, 8'h00);

    // PHY keeps dir high after the read byte: no stp, error, read data kept
    arm(8'hC5, -1, 1, -1);
    accept(1'b0, 8'h05, 8'h00);
    send_byte(8'hC5, 0);
    expect_o(8'h00, 1'b0, 1'b1, 1'b0); ulpi_dir = 1'b1; tick();
    expect_o(8'h00, 1'b0, 1'b1, 1'b0); ulpi_dir = 1'b1; ulpi_din = 8'h77; tick();
    for (int k = 0; k < TMO; k++) begin
      expect_o(8'h00, 1'b0, 1'b1, 1'b0);
      ulpi_dir = 1'b1;
      tick();
    end
    finish_rsp(1'b1, 1'b0, 8'h00);

    // Reset during WDATA: everything back to reset values, no response
    arm(8'h96, -1, -1, -1);
    accept(1'b1, 8'h16, 8'h5A);
    send_byte(8'h96, 0);
    expect_o(8'h5A, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_o(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; m_err = 1'b0; m_rdata = 8'h00;
    tick();
    expect_o(8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    arm(8'h96, 4, 1, -1);   write_txn(8'h16, 8'hA5, 0, 0);
    arm(8'hC1, 5, 1, 8'h42); read_txn(8'h01, 0, 8'h42);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
